ctrl_decode_pipe: RTL and testbench

- Registered, flow-controlled decode-stage control generator. Successor to the combinational opcode decoder.
- Accepts one 32-bit instruction per cycle tagged with a hart ID. Produces the full control bundle, including M-extension and illegal-instruction decode, through a parametrised skid FIFO.
- Serialises SYSTEM and illegal instructions per hart until the execute stage retires them.
- Sits between fetch and the register-read/execute boundary of the multicore pipeline.

---
 rtl/ctrl_decode_pipe.sv | 270 +++++++++++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe.sv
// Registered decode stage: decodes one instruction per cycle into a control
// bundle, buffers it in a skid FIFO and serialises SYSTEM/illegal
// instructions per hart until execute reports them retired.

package ctrl_decode_pkg;
   typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND} aluop_e;
   typedef enum logic [2:0] {BEQ = 3'd0, BNE = 3'd1, BLT = 3'd4, BGE = 3'd5,
                             BLTU = 3'd6, BGEU = 3'd7} brop_e;
   typedef enum logic [2:0] {RDCYCLE, RDCYCLEH, RDTIME, RDTIMEH, RDINSTRET, RDINSTRETH,
                             SCALL, SBREAK} sysop_e;
   typedef enum logic [1:0] {ALU, BRANCH, SYSTEM_UNIT} exe_unit_e;
   typedef enum logic [2:0] {LW, LB, LH, LBU, LHU} ldop_e;
   typedef enum logic [1:0] {SW, SB, SH} sop_e;

   // All-zero value is the idle bundle (ADD/BEQ/RDCYCLE/LW/SW, no side effects).
   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       regwrite;
      logic       memwrite;
      logic       memaccess;
      logic       alu_srcb;
      logic       jalr;
      logic [1:0] memtoreg;
      logic [1:0] alu_srca;
      aluop_e     aluop;
      brop_e      brop;
      sysop_e     sysop;
      exe_unit_e  exe_unit;
      ldop_e      ldop;
      sop_e       sop;
      logic       muldiv;
      logic [2:0] mdop;
      logic       illegal;
   } bundle_t;
endpackage

module ctrl_decode_pipe
   import ctrl_decode_pkg::*;
#(
   parameter int NUM_HARTS  = 2,
   parameter bit EN_MULDIV  = 1'b1,
   parameter int FIFO_DEPTH = 2,
   localparam int HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [31:0]          i_instr,
   input  logic [HART_W-1:0]    i_hart,
   input  logic [NUM_HARTS-1:0] i_sys_done,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [HART_W-1:0]    o_hart,
   output logic [4:0]           o_rd,
   output logic [4:0]           o_rs1,
   output logic [4:0]           o_rs2,
   output logic                 o_regwrite,
   output logic                 o_memwrite,
   output logic                 o_memaccess,
   output logic                 o_alu_srcb,
   output logic                 o_jalr,
   output logic [1:0]           o_memtoreg,
   output logic [1:0]           o_alu_srca,
   output aluop_e               o_aluop,
   output brop_e                o_brop,
   output sysop_e               o_sysop,
   output exe_unit_e            o_exe_unit,
   output ldop_e                o_ldop,
   output sop_e                 o_sop,
   output logic                 o_muldiv,
   output logic [2:0]           o_mdop,
   output logic                 o_illegal,
   output logic [NUM_HARTS-1:0] o_hart_locked
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_ALCI = 7'b0010011,
                          OP_ALCR = 7'b0110011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                          OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011,
                          OP_SYSTEM = 7'b1110011;

   typedef enum logic {RUN, LOCKED} lock_state_e;

   function automatic aluop_e alu_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? SUB : ADD;
         3'b001:  return SLL;
         3'b010:  return SLT;
         3'b011:  return SLTU;
         3'b100:  return XOR;
         3'b101:  return alt ? SRA : SRL;
         3'b110:  return OR;
         default: return AND;
      endcase
   endfunction

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [11:0] csr;
   bundle_t     dec, head;
   logic        bad, use_rd, use_rs1, use_rs2;
   logic        accept, pop, hart_lk;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt;
   bundle_t          mem  [FIFO_DEPTH];
   logic [HART_W-1:0] hmem [FIFO_DEPTH];

   assign opc = i_instr[6:0];
   assign f3  = i_instr[14:12];
   assign f7  = i_instr[31:25];
   assign csr = i_instr[31:20];

   // Decode; register fields are passed only for formats that use them.
   always_comb begin
      dec = '0; bad = 1'b0; use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
      case (opc)
         OP_LOAD: begin
            dec.regwrite = 1'b1; dec.memtoreg = 2'b01; dec.alu_srcb = 1'b1;
            dec.memaccess = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            case (f3)
               3'b000:  dec.ldop = LB;
               3'b001:  dec.ldop = LH;
               3'b100:  dec.ldop = LBU;
               3'b101:  dec.ldop = LHU;
               default: dec.ldop = LW;
            endcase
         end
         OP_STORE: begin
            dec.memwrite = 1'b1; dec.memaccess = 1'b1; dec.alu_srcb = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (f3)
               3'b000:  dec.sop = SB;
               3'b001:  dec.sop = SH;
               default: dec.sop = SW;
            endcase
         end
         OP_ALCI: begin
            dec.regwrite = 1'b1; dec.alu_srcb = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            // only the shift-right slot carries an alternate op for immediates
            dec.aluop = alu_sel(f3, (f3 == 3'b101) && f7[5]);
         end
         OP_ALCR: begin
            dec.regwrite = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            if (f7 == 7'b0000000 || f7 == 7'b0100000) dec.aluop = alu_sel(f3, f7[5]);
            else if (EN_MULDIV && f7 == 7'b0000001) begin
               dec.muldiv = 1'b1; dec.mdop = f3;
            end else bad = 1'b1;
         end
         OP_LUI:   begin dec.regwrite = 1'b1; dec.alu_srca = 2'd2; dec.alu_srcb = 1'b1; use_rd = 1'b1; end
         OP_AUIPC: begin dec.regwrite = 1'b1; dec.alu_srca = 2'd1; use_rd = 1'b1; end
         OP_JAL:   begin dec.regwrite = 1'b1; dec.memtoreg = 2'b10; use_rd = 1'b1; end
         OP_JALR: begin
            dec.regwrite = 1'b1; dec.memtoreg = 2'b10; dec.jalr = 1'b1;
            use_rd = 1'b1; use_rs1 = 1'b1;
         end
         OP_BRANCH: begin
            dec.exe_unit = BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (f3)
               3'b001:  dec.brop = BNE;
               3'b100:  dec.brop = BLT;
               3'b101:  dec.brop = BGE;
               3'b110:  dec.brop = BLTU;
               3'b111:  dec.brop = BGEU;
               default: dec.brop = BEQ;
            endcase
         end
         OP_SYSTEM: begin
            dec.exe_unit = SYSTEM_UNIT;
            if (f3 == 3'b000) dec.sysop = i_instr[20] ? SBREAK : SCALL;
            else if (f3 == 3'b010) begin
               dec.regwrite = 1'b1; use_rd = 1'b1;
               case (csr)
                  12'hC00: dec.sysop = RDCYCLE;
                  12'hC80: dec.sysop = RDCYCLEH;
                  12'hC01: dec.sysop = RDTIME;
                  12'hC81: dec.sysop = RDTIMEH;
                  12'hC02: dec.sysop = RDINSTRET;
                  12'hC82: dec.sysop = RDINSTRETH;
                  default: bad = 1'b1;
               endcase
            end else bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      if (use_rd)  dec.rd  = i_instr[11:7];
      if (use_rs1) dec.rs1 = i_instr[19:15];
      if (use_rs2) dec.rs2 = i_instr[24:20];
      if (bad) begin
         dec = '0; dec.illegal = 1'b1; dec.exe_unit = SYSTEM_UNIT;
      end
   end

   // Lock state of the issuing hart (out-of-range tags read as unlocked).
   always_comb begin
      hart_lk = 1'b0;
      for (int h = 0; h < NUM_HARTS; h++)
         if (i_hart == HART_W'(h)) hart_lk = o_hart_locked[h];
   end

   assign o_valid = (cnt != '0);
   assign pop     = o_valid & i_ready;
   assign o_ready = !i_rst && !i_flush && ((cnt < CNT_W'(FIFO_DEPTH)) || pop) && !hart_lk;
   assign accept  = i_valid & o_ready;

   // FIFO pointers and occupancy; flush wins over push/pop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0; rd_ptr <= '0; cnt <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0; rd_ptr <= '0; cnt <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
         cnt <= cnt + CNT_W'(accept) - CNT_W'(pop);
      end
   end

   // Entry storage; contents only matter while counted as valid.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         mem[wr_ptr]  <= dec;
         hmem[wr_ptr] <= i_hart;
      end
   end

   // Empty FIFO presents the idle bundle so nothing undefined escapes.
   assign head   = o_valid ? mem[rd_ptr] : '0;
   assign o_hart = o_valid ? hmem[rd_ptr] : '0;

   assign o_rd = head.rd;             assign o_rs1 = head.rs1;           assign o_rs2 = head.rs2;
   assign o_regwrite = head.regwrite; assign o_memwrite = head.memwrite;
   assign o_memaccess = head.memaccess; assign o_alu_srcb = head.alu_srcb;
   assign o_jalr = head.jalr;         assign o_memtoreg = head.memtoreg; assign o_alu_srca = head.alu_srca;
   assign o_aluop = head.aluop;       assign o_brop = head.brop;         assign o_sysop = head.sysop;
   assign o_exe_unit = head.exe_unit; assign o_ldop = head.ldop;         assign o_sop = head.sop;
   assign o_muldiv = head.muldiv;     assign o_mdop = head.mdop;         assign o_illegal = head.illegal;

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      lock_state_e st, st_nxt;
      logic        lock_set;

      assign lock_set = accept && (dec.exe_unit == SYSTEM_UNIT) && (i_hart == HART_W'(h));

      // Per-hart lock state register.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) st <= RUN;
         else       st <= st_nxt;
      end

      // Lock on SYSTEM/illegal acceptance, release on retire; new lock beats done.
      always_comb begin
         st_nxt = st;
         if (i_flush) st_nxt = RUN;
         else begin
            case (st)
               RUN:     if (lock_set) st_nxt = LOCKED;
               LOCKED:  if (i_sys_done[h] && !lock_set) st_nxt = RUN;
               default: st_nxt = RUN;
            endcase
         end
      end

      assign o_hart_locked[h] = (st == LOCKED);
   end
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed + random bench for ctrl_decode_pipe against a queue-based model.
module tb_ctrl_decode_pipe;
   import ctrl_decode_pkg::*;

   localparam int NH = 2, HW = 1, DEPTH = 2;

   typedef struct {
      logic [HW-1:0] hart;
      bundle_t       b;
   } ent_t;

   logic i_clk = 1'b0, i_rst, i_flush, i_valid, i_ready;
   logic [31:0] i_instr;
   logic [HW-1:0] i_hart;
   logic [NH-1:0] i_sys_done;
   logic o_ready, o_valid;
   logic [HW-1:0] o_hart;
   logic [4:0] o_rd, o_rs1, o_rs2;
   logic o_regwrite, o_memwrite, o_memaccess, o_alu_srcb, o_jalr;
   logic [1:0] o_memtoreg, o_alu_srca;
   aluop_e o_aluop; brop_e o_brop; sysop_e o_sysop; exe_unit_e o_exe_unit; ldop_e o_ldop; sop_e o_sop;
   logic o_muldiv, o_illegal;
   logic [2:0] o_mdop;
   logic [NH-1:0] o_hart_locked;

   // second instance without RV32M
   logic v2, r2;
   logic [NH-1:0] done2;
   logic d2_ready, d2_valid;
   logic [HW-1:0] d2_hart;
   logic [4:0] d2_rd, d2_rs1, d2_rs2;
   logic d2_regwrite, d2_memwrite, d2_memaccess, d2_alu_srcb, d2_jalr;
   logic [1:0] d2_memtoreg, d2_alu_srca;
   aluop_e d2_aluop; brop_e d2_brop; sysop_e d2_sysop; exe_unit_e d2_exe_unit; ldop_e d2_ldop; sop_e d2_sop;
   logic d2_muldiv, d2_illegal;
   logic [2:0] d2_mdop;
   logic [NH-1:0] d2_locked;

   int checks = 0, errors = 0;
   ent_t mq[$];
   logic [NH-1:0] mlock;

   ctrl_decode_pipe #(.NUM_HARTS(NH), .EN_MULDIV(1'b1), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
      .i_instr(i_instr), .i_hart(i_hart), .i_sys_done(i_sys_done), .o_valid(o_valid),
      .i_ready(i_ready), .o_hart(o_hart), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
      .o_regwrite(o_regwrite), .o_memwrite(o_memwrite), .o_memaccess(o_memaccess),
      .o_alu_srcb(o_alu_srcb), .o_jalr(o_jalr), .o_memtoreg(o_memtoreg), .o_alu_srca(o_alu_srca),
      .o_aluop(o_aluop), .o_brop(o_brop), .o_sysop(o_sysop), .o_exe_unit(o_exe_unit),
      .o_ldop(o_ldop), .o_sop(o_sop), .o_muldiv(o_muldiv), .o_mdop(o_mdop),
      .o_illegal(o_illegal), .o_hart_locked(o_hart_locked));

   ctrl_decode_pipe #(.NUM_HARTS(NH), .EN_MULDIV(1'b0), .FIFO_DEPTH(DEPTH)) dut2 (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(v2), .o_ready(d2_ready),
      .i_instr(i_instr), .i_hart(i_hart), .i_sys_done(done2), .o_valid(d2_valid),
      .i_ready(r2), .o_hart(d2_hart), .o_rd(d2_rd), .o_rs1(d2_rs1), .o_rs2(d2_rs2),
      .o_regwrite(d2_regwrite), .o_memwrite(d2_memwrite), .o_memaccess(d2_memaccess),
      .o_alu_srcb(d2_alu_srcb), .o_jalr(d2_jalr), .o_memtoreg(d2_memtoreg), .o_alu_srca(d2_alu_srca),
      .o_aluop(d2_aluop), .o_brop(d2_brop), .o_sysop(d2_sysop), .o_exe_unit(d2_exe_unit),
      .o_ldop(d2_ldop), .o_sop(d2_sop), .o_muldiv(d2_muldiv), .o_mdop(d2_mdop),
      .o_illegal(d2_illegal), .o_hart_locked(d2_locked));

   initial forever #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bundle_t got_bundle();
      bundle_t g;
      g.rd = o_rd; g.rs1 = o_rs1; g.rs2 = o_rs2; g.regwrite = o_regwrite; g.memwrite = o_memwrite;
      g.memaccess = o_memaccess; g.alu_srcb = o_alu_srcb; g.jalr = o_jalr; g.memtoreg = o_memtoreg;
      g.alu_srca = o_alu_srca; g.aluop = o_aluop; g.brop = o_brop; g.sysop = o_sysop;
      g.exe_unit = o_exe_unit; g.ldop = o_ldop; g.sop = o_sop; g.muldiv = o_muldiv;
      g.mdop = o_mdop; g.illegal = o_illegal;
      return g;
   endfunction

   // Reference decode written from the instruction-class rules.
   function automatic bundle_t ref_dec(input logic [31:0] w, input bit md);
      bundle_t b;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [11:0] csr_tbl [6];
      aluop_e alu_tbl [8];
      bit ill;
      alu_tbl = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
      csr_tbl = '{12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82};
      b = '0; ill = 0; f3 = w[14:12]; f7 = w[31:25];
      case (w[6:0])
         7'h03: begin
            b.regwrite = 1; b.memtoreg = 2'd1; b.alu_srcb = 1; b.memaccess = 1;
            b.rd = w[11:7]; b.rs1 = w[19:15];
            b.ldop = (f3 == 0) ? LB : (f3 == 1) ? LH : (f3 == 4) ? LBU : (f3 == 5) ? LHU : LW;
         end
         7'h23: begin
            b.memwrite = 1; b.memaccess = 1; b.alu_srcb = 1; b.rs1 = w[19:15]; b.rs2 = w[24:20];
            b.sop = (f3 == 0) ? SB : (f3 == 1) ? SH : SW;
         end
         7'h13: begin
            b.regwrite = 1; b.alu_srcb = 1; b.rd = w[11:7]; b.rs1 = w[19:15];
            b.aluop = alu_tbl[f3];
            if (f3 == 5 && w[30]) b.aluop = SRA;
         end
         7'h33: begin
            b.regwrite = 1; b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20];
            if (f7 == 7'h00 || f7 == 7'h20) begin
               b.aluop = alu_tbl[f3];
               if (w[30] && f3 == 0) b.aluop = SUB;
               if (w[30] && f3 == 5) b.aluop = SRA;
            end else if (md && f7 == 7'h01) begin
               b.muldiv = 1; b.mdop = f3;
            end else ill = 1;
         end
         7'h37: begin b.regwrite = 1; b.alu_srca = 2; b.alu_srcb = 1; b.rd = w[11:7]; end
         7'h17: begin b.regwrite = 1; b.alu_srca = 1; b.rd = w[11:7]; end
         7'h6F: begin b.regwrite = 1; b.memtoreg = 2; b.rd = w[11:7]; end
         7'h67: begin b.regwrite = 1; b.memtoreg = 2; b.jalr = 1; b.rd = w[11:7]; b.rs1 = w[19:15]; end
         7'h63: begin
            b.exe_unit = BRANCH; b.rs1 = w[19:15]; b.rs2 = w[24:20];
            b.brop = (f3 == 2 || f3 == 3) ? BEQ : brop_e'(f3);
         end
         7'h73: begin
            b.exe_unit = SYSTEM_UNIT;
            if (f3 == 0) b.sysop = w[20] ? SBREAK : SCALL;
            else if (f3 == 2) begin
               ill = 1;
               for (int i = 0; i < 6; i++)
                  if (w[31:20] == csr_tbl[i]) begin ill = 0; b.sysop = sysop_e'(i); end
               b.regwrite = 1; b.rd = w[11:7];
            end else ill = 1;
         end
         default: ill = 1;
      endcase
      if (ill) begin b = '0; b.illegal = 1; b.exe_unit = SYSTEM_UNIT; end
      return b;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [31:0] w;
      logic [6:0] ops [12];
      logic [11:0] csrs [7];
      ops  = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h73, 7'h0F, 7'h7F};
      csrs = '{12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82, 12'hC03};
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 11)];
      if (w[6:0] == 7'h33)
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
         endcase
      if (w[6:0] == 7'h73) begin
         case ($urandom_range(0, 2))
            0: w[14:12] = 3'd0;
            1: w[14:12] = 3'd2;
            default: ;
         endcase
         if ($urandom_range(0, 3) != 0) w[31:20] = csrs[$urandom_range(0, 6)];
      end
      return w;
   endfunction

   // One clock: drive at negedge, check, then advance the model past the edge.
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [HW-1:0] h,
                      input logic rdy, input logic [NH-1:0] done, input logic fl);
      bit pop, exp_rdy, acc;
      bundle_t eb;
      i_valid = v; i_instr = ins; i_hart = h; i_ready = rdy; i_sys_done = done; i_flush = fl;
      #1;
      chk("o_valid", 64'(o_valid), 64'(mq.size() != 0));
      chk("o_hart_locked", 64'(o_hart_locked), 64'(mlock));
      if (mq.size() != 0) begin
         chk("o_hart", 64'(o_hart), 64'(mq[0].hart));
         chk("head bundle", 64'(got_bundle()), 64'(mq[0].b));
      end
      pop = (mq.size() != 0) && rdy;
      exp_rdy = !fl && ((mq.size() < DEPTH) || pop) && !mlock[h];
      chk("o_ready", 64'(o_ready), 64'(exp_rdy));
      acc = v && exp_rdy;
      eb = ref_dec(ins, 1'b1);
      @(posedge i_clk);
      if (fl) begin
         mq.delete(); mlock = '0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back('{hart: h, b: eb});
         for (int k = 0; k < NH; k++)
            if (acc && h == HW'(k) && (eb.illegal || ins[6:0] == 7'h73)) mlock[k] = 1'b1;
            else if (done[k]) mlock[k] = 1'b0;
      end
      @(negedge i_clk);
   endtask

   task automatic drain();
      repeat (4) cyc(1'b0, 32'h0, '0, 1'b1, '0, 1'b0);
   endtask

   localparam logic [31:0] ADDI = 32'h00A28293, RDCYC = 32'hC0002573, MUL = 32'h02B50533;

   initial begin
      i_rst = 1'b1; i_flush = 0; i_valid = 0; i_ready = 0; i_instr = 0; i_hart = 0; i_sys_done = 0;
      v2 = 0; r2 = 1; done2 = 0; mlock = '0;
      repeat (2) @(negedge i_clk);
      #1;
      chk("reset o_valid", 64'(o_valid), 64'(0));
      chk("reset o_ready", 64'(o_ready), 64'(0));
      chk("reset locked", 64'(o_hart_locked), 64'(0));
      chk("reset head", 64'(got_bundle()), 64'(0));
      @(negedge i_clk);
      i_rst = 1'b0;

      // single addi
      cyc(1, ADDI, 0, 1, '0, 0);
      chk("addi valid", 64'(o_valid), 64'(1));
      chk("addi rd", 64'(o_rd), 64'(5));
      chk("addi rs1", 64'(o_rs1), 64'(5));
      chk("addi aluop", 64'(o_aluop), 64'(ADD));
      chk("addi srcb", 64'(o_alu_srcb), 64'(1));
      chk("addi regwrite", 64'(o_regwrite), 64'(1));
      chk("addi illegal", 64'(o_illegal), 64'(0));
      drain();

      // stall fill, full-with-pop acceptance, ordered drain
      cyc(1, 32'h00100093, 0, 0, '0, 0);
      cyc(1, 32'h40208133, 0, 0, '0, 0);
      cyc(1, 32'h0031A223, 0, 0, '0, 0);
      chk("full ready", 64'(o_ready), 64'(0));
      cyc(1, 32'h0031A223, 0, 1, '0, 0);
      drain();

      // SYSTEM lock on hart 1, hart 0 keeps flowing
      cyc(1, RDCYC, 1, 0, '0, 0);
      chk("rdcycle sysop", 64'(o_sysop), 64'(RDCYCLE));
      chk("rdcycle lock", 64'(o_hart_locked), 64'(2'b10));
      cyc(1, ADDI, 1, 0, '0, 0);
      cyc(1, 32'h00630313, 0, 1, '0, 0);
      cyc(0, 32'h0, 0, 1, 2'b10, 0);
      chk("unlock", 64'(o_hart_locked), 64'(0));
      drain();

      // mul with and without RV32M
      v2 = 1;
      cyc(1, MUL, 0, 0, '0, 0);
      v2 = 0;
      chk("mul muldiv", 64'(o_muldiv), 64'(1));
      chk("mul mdop", 64'(o_mdop), 64'(0));
      chk("nomd valid", 64'(d2_valid), 64'(1));
      chk("nomd illegal", 64'(d2_illegal), 64'(1));
      chk("nomd regwrite", 64'(d2_regwrite), 64'(0));
      chk("nomd locked", 64'(d2_locked), 64'(2'b01));
      drain();

      // illegal opcode then flush with input dropped
      cyc(1, 32'h0000007F, 0, 0, '0, 0);
      chk("bad opcode illegal", 64'(o_illegal), 64'(1));
      cyc(1, ADDI, 1, 0, '0, 0);
      cyc(1, ADDI, 1, 1, '0, 1);
      chk("flush valid", 64'(o_valid), 64'(0));
      chk("flush locked", 64'(o_hart_locked), 64'(0));
      chk("flush locked nomd", 64'(d2_locked), 64'(0));
      drain();

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         logic [NH-1:0] dn;
         for (int k = 0; k < NH; k++) dn[k] = ($urandom_range(0, 3) == 0);
         cyc($urandom_range(0, 3) != 0, rnd_instr(), HW'($urandom_range(0, NH - 1)),
             $urandom_range(0, 3) != 0, dn, $urandom_range(0, 59) == 0);
      end
      drain();

      // asynchronous reset in the middle of a stall
      cyc(1, RDCYC, 1, 0, '0, 0);
      cyc(1, ADDI, 0, 0, '0, 0);
      i_valid = 0;
      #2 i_rst = 1'b1;
      #1;
      chk("async rst valid", 64'(o_valid), 64'(0));
      chk("async rst locked", 64'(o_hart_locked), 64'(0));
      chk("async rst ready", 64'(o_ready), 64'(0));
      chk("async rst head", 64'(got_bundle()), 64'(0));
      mq.delete(); mlock = '0;
      @(negedge i_clk);
      i_rst = 1'b0;
      cyc(1, ADDI, 0, 0, '0, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
